adc_frame_rx: RTL and testbench
===============================

# adc_frame_rx

Serial-to-parallel front end for the 32-tap FIR filter. It deserialises MSB-first 16-bit two's-complement words from a framed serial ADC link. For each accepted word it presents the word on `xOut` with a one-cycle `sample` strobe, which connect directly to the filter's `xIn`/`sample` inputs. It enforces a minimum spacing between strobes so that every strobe lands after the filter's 32-cycle MAC pass has finished, and it flags frames dropped for overrun or broken framing.

## Interface
Parameters:
- `WIDTH`, 16: serial word length and `xOut` width.
- `GUARD`, 34: minimum clock cycles between consecutive `sample` pulses (32 MAC cycles + clear + output).

Ports:
- `clk`  in  1  system clock. One clock domain; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bit_en`  in  1  bit-clock qualifier. `sdata`/`fs` are sampled only on cycles with `bit_en`=1.
- `fs`  in  1  frame sync. High on a `bit_en` cycle marks that bit as the MSB of a new word.
- `sdata`  in  1  serial data, MSB first.
- `err_clr`  in  1  one-cycle clear of the sticky flags.
- `xOut`  out  WIDTH  last accepted word. Registered; held between accepts.
- `sample`  out  1  one-cycle strobe; `xOut` is new on this cycle.
- `overrun`  out  1  sticky: a complete word was dropped by the guard.
- `frame_err`  out  1  sticky: `fs` arrived mid-word.

## Operation
- States:
  - IDLE: wait for `bit_en & fs`.
  - SHIFT: collect the remaining WIDTH-1 bits.
- IDLE → SHIFT on `bit_en & fs`: shift register gets `sdata` as MSB; bit counter = 1.
- In SHIFT, each `bit_en` cycle with `fs`=0 shifts in `sdata` and increments the bit counter.
- Word completes when the bit counter reaches WIDTH-1 and another `bit_en` cycle captures the LSB. State returns to IDLE on that cycle.
- In SHIFT, `bit_en & fs` before completion:
  - set `frame_err`.
  - discard the partial word.
  - restart with this bit as MSB (bit counter = 1); stay in SHIFT.
- `fs` on a cycle with `bit_en`=0 is ignored. `fs` on the LSB cycle is ignored as sync; the word completes normally.
- Gap counter:
  - reset to 0 on every cycle `sample`=1.
  - increments every other cycle, saturating at GUARD.
  - reset value GUARD, so the first word after reset is always accepted.
- On word completion:
  - If gap ≥ GUARD-1: accept. `xOut` loads the assembled word and `sample`=1 on the next edge.
  - Otherwise: drop. `xOut`/`sample` unchanged; `overrun` set on the next edge.
- Sticky flags:
  - set on their event.
  - cleared by `err_clr`. Set wins if set and `err_clr` coincide.
  - cleared by `reset`.
- Data is passed bit-exact; no sign handling or arithmetic.

## Timing
- Reset values:
  - `xOut`=0, `sample`=0, `overrun`=0, `frame_err`=0.
  - state IDLE, bit counter 0, gap = GUARD.
- `reset` asserted mid-word discards the partial word. Nothing is emitted until the next `fs`.
- Latency: `sample` and new `xOut` appear 1 clock after the `bit_en` cycle that captured the LSB.
- `sample` is never high on two consecutive cycles. Accepted strobes are always ≥ GUARD cycles apart.
- `bit_en` may be high every cycle (max rate: one word per WIDTH cycles), which forces drops when WIDTH < GUARD.
- No backpressure; the downstream filter is not polled.

## Structure
- Shared package `fir_pkg`:
  - `FIR_WORD_W` = 16
  - `FIR_TAPS` = 32
  - `FIR_GUARD` = `FIR_TAPS`+2
  - state enum {IDLE, SHIFT}
- One sub-module, `sample_gap_counter`: saturating up-counter with synchronous clear and `ready` = (count ≥ GUARD-1).
- Shift register, bit counter and FSM are inline.

## Test plan
- Reset, then one frame of 0xA5C3 with `bit_en` every 4th cycle → `sample` pulses once, 1 clock after the LSB `bit_en`; `xOut`=0xA5C3; both flags 0.
- Two frames 0x8000, 0x7FFF with `bit_en` every cycle, back-to-back (16 cycles apart) → first accepted (`xOut`=0x8000); second dropped; `overrun`=1; `xOut` stays 0x8000.
- Same two frames with `bit_en` every 3rd cycle (48 cycles apart) → both accepted; `sample` pulses 48 cycles apart; `xOut`=0x7FFF; `overrun`=0.
- `fs` re-asserted after 7 bits, then a full 0x1234 → `frame_err`=1; exactly one `sample`; `xOut`=0x1234.
- `reset` pulsed after 10 bits of a word, then a full 0x00FF frame → no `sample` for the aborted word; `xOut`=0x00FF after the second frame; flags 0.
- `overrun` set, then `err_clr` pulsed on the same cycle as a new drop → `overrun` remains 1; `err_clr` alone on a later cycle → `overrun`=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR front end.
// Word width, tap count and the strobe guard interval.
package fir_pkg;

    localparam int FIR_WORD_W = 16;
    localparam int FIR_TAPS   = 32;
    localparam int FIR_GUARD  = FIR_TAPS + 2;

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_t;

    // Counter width able to hold values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_frame_rx_if.sv
// Serial ADC link plus parallel sample output bundle.
// master drives the link, slave is the receiver.
interface adc_frame_rx_if #(
    parameter int WIDTH = fir_pkg::FIR_WORD_W
);

    logic             bit_en;
    logic             fs;
    logic             sdata;
    logic             err_clr;
    logic [WIDTH-1:0] xOut;
    logic             sample;
    logic             overrun;
    logic             frame_err;

    modport master (
        output bit_en, fs, sdata, err_clr,
        input  xOut, sample, overrun, frame_err
    );

    modport slave (
        input  bit_en, fs, sdata, err_clr,
        output xOut, sample, overrun, frame_err
    );

endinterface

// File: rtl/sample_gap_counter.sv
// Saturating count of cycles since the last sample strobe.
// ready means another strobe may be issued safely.
module sample_gap_counter
    import fir_pkg::*;
#(
    parameter int GUARD = FIR_GUARD
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_ready
);

    localparam int            CW  = $clog2(GUARD + 1);
    localparam logic [CW-1:0] MAX = CW'(GUARD);
    localparam logic [CW-1:0] RDY = CW'(GUARD - 1);

    logic [CW-1:0] r_cnt;

    // Start saturated so the first word after reset is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= MAX;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_ready = (r_cnt >= RDY);

endmodule

// File: rtl/adc_frame_rx.sv
// Framed MSB-first serial ADC receiver feeding the FIR filter.
// Spaces sample strobes and flags overrun / framing errors.
module adc_frame_rx
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WORD_W,
    parameter int GUARD = FIR_GUARD
) (
    input logic           clk,
    input logic           reset,
    adc_frame_rx_if.slave bus
);

    localparam int            BW   = cnt_w(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [BW-1:0]    r_bitcnt;
    logic [WIDTH-2:0] r_shift;
    logic [WIDTH-1:0] r_xout;
    logic             r_sample;
    logic             r_ovr;
    logic             r_ferr;

    logic             w_start;
    logic             w_shift;
    logic             w_done;
    logic             w_ferr_set;
    logic             w_ready;
    logic             w_accept;
    logic             w_drop;
    logic [WIDTH-1:0] w_word;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-bit control; fs on the LSB bit is not a sync.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_ferr_set  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.bit_en && bus.fs) begin
                    w_start     = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_en) begin
                    if (r_bitcnt == LAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (bus.fs) begin
                        w_start    = 1'b1;
                        w_ferr_set = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_word   = {r_shift, bus.sdata};
    assign w_accept = w_done & w_ready;
    assign w_drop   = w_done & ~w_ready;

    // Shift register and bit counter; a new MSB discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else if (w_start) begin
            r_shift  <= {{(WIDTH-2){1'b0}}, bus.sdata};
            r_bitcnt <= BW'(1);
        end else if (w_shift) begin
            r_shift  <= {r_shift[WIDTH-3:0], bus.sdata};
            r_bitcnt <= r_bitcnt + 1'b1;
        end else if (w_done) begin
            r_bitcnt <= '0;
        end
    end

    // Output word and strobe, updated only for accepted words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_xout   <= '0;
            r_sample <= 1'b0;
        end else begin
            r_sample <= w_accept;
            if (w_accept) begin
                r_xout <= w_word;
            end
        end
    end

    // Sticky flags; a new event beats a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= w_drop | (r_ovr & ~bus.err_clr);
            r_ferr <= w_ferr_set | (r_ferr & ~bus.err_clr);
        end
    end

    sample_gap_counter #(
        .GUARD (GUARD)
    ) u_gap (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (r_sample),
        .o_ready (w_ready)
    );

    assign bus.xOut      = r_xout;
    assign bus.sample    = r_sample;
    assign bus.overrun   = r_ovr;
    assign bus.frame_err = r_ferr;

endmodule

// File: tb/tb_adc_frame_rx.sv
// Testbench for adc_frame_rx.
// Directed scenarios plus random frames against a cycle-numbered model.
module tb_adc_frame_rx;
    import fir_pkg::*;

    localparam int W = FIR_WORD_W;
    localparam int G = FIR_GUARD;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    adc_frame_rx_if #(.WIDTH(W)) bus ();

    adc_frame_rx #(
        .WIDTH (W),
        .GUARD (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    // Model: words in progress, cycle of last strobe, expected strobes.
    bit             m_inw;
    int             m_nb;
    logic [W-1:0]   m_word;
    logic [W-1:0]   m_xout;
    int             m_last;
    bit             m_ovr;
    bit             m_ferr;
    int             exp_cyc[$];
    logic [W-1:0]   exp_val[$];
    int             got_cyc[$];
    logic [W-1:0]   got_val[$];

    task automatic model_step(input logic be, input logic fs,
                              input logic sd, input logic clr,
                              input logic rst);
        bit ov_set;
        bit fe_set;
        ov_set = 0;
        fe_set = 0;
        if (rst) begin
            m_inw  = 0;
            m_nb   = 0;
            m_word = '0;
            m_xout = '0;
            m_last = -1000;
            m_ovr  = 0;
            m_ferr = 0;
            return;
        end
        if (be) begin
            if (m_inw && m_nb == W - 1) begin
                m_word = {m_word[W-2:0], sd};
                m_inw  = 0;
                m_nb   = 0;
                // Strobe at cyc+1; counter is cleared the cycle after a strobe.
                if (cyc - m_last >= G) begin
                    m_last = cyc + 1;
                    m_xout = m_word;
                    exp_cyc.push_back(cyc + 1);
                    exp_val.push_back(m_word);
                end else begin
                    ov_set = 1;
                end
            end else if (fs) begin
                if (m_inw) fe_set = 1;
                m_inw  = 1;
                m_nb   = 1;
                m_word = {{(W-1){1'b0}}, sd};
            end else if (m_inw) begin
                m_word = {m_word[W-2:0], sd};
                m_nb++;
            end
        end
        if (ov_set) m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (fe_set) m_ferr = 1;
        else if (clr) m_ferr = 0;
    endtask

    task automatic tick(input logic be, input logic fs, input logic sd,
                        input logic clr, input logic rst);
        reset       = rst;
        bus.bit_en  = be;
        bus.fs      = fs;
        bus.sdata   = sd;
        bus.err_clr = clr;
        model_step(be, fs, sd, clr, rst);
        @(posedge clk);
        #1;
        cyc++;
        if (bus.sample === 1'b1) begin
            got_cyc.push_back(cyc);
            got_val.push_back(bus.xOut);
        end
    endtask

    task automatic idle(input int n, input bit rnd_clr);
        for (int k = 0; k < n; k++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rnd_clr ? 1'($urandom_range(0, 7) == 0) : 1'b0, 1'b0);
        end
    endtask

    task automatic send_bits(input logic [W-1:0] word, input int nbits,
                             input int period, input bit fs_lsb,
                             input bit clr_lsb);
        logic sd;
        for (int i = 0; i < nbits; i++) begin
            sd = word[W-1-i];
            tick(1'b1, (i == 0) || (fs_lsb && i == W - 1), sd,
                 clr_lsb && i == W - 1, 1'b0);
            for (int k = 1; k < period; k++) begin
                tick(1'b0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cyc.delete();
        exp_val.delete();
        got_cyc.delete();
        got_val.delete();
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tot++;
        if (bus.xOut !== 16'h0000)
            $display("FAIL reset_xout got %h want 0000", bus.xOut);
        else n_pass++;
        n_tot++;
        if (bus.sample !== 1'b0)
            $display("FAIL reset_sample got %b want 0", bus.sample);
        else n_pass++;
        n_tot++;
        if (bus.overrun !== 1'b0)
            $display("FAIL reset_overrun got %b want 0", bus.overrun);
        else n_pass++;
        n_tot++;
        if (bus.frame_err !== 1'b0)
            $display("FAIL reset_frame_err got %b want 0", bus.frame_err);
        else n_pass++;
    endtask

    task automatic test_single();
        int start;
        do_reset();
        start = cyc;
        send_bits(16'hA5C3, W, 4, 0, 0);
        idle(10, 0);
        n_tot++;
        if (got_cyc.size() != 1)
            $display("FAIL single_count got %0d want 1", got_cyc.size());
        else n_pass++;
        n_tot++;
        if (got_cyc.size() < 1 || got_cyc[0] != start + (W - 1) * 4 + 1)
            $display("FAIL single_latency got %0d want %0d",
                     got_cyc.size() ? got_cyc[0] : -1,
                     start + (W - 1) * 4 + 1);
        else n_pass++;
        n_tot++;
        if (bus.xOut !== 16'hA5C3)
            $display("FAIL single_xout got %h want a5c3", bus.xOut);
        else n_pass++;
        n_tot++;
        if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0)
            $display("FAIL single_flags got %b%b want 00",
                     bus.overrun, bus.frame_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_bits(16'h8000, W, 1, 0, 0);
        send_bits(16'h7FFF, W, 1, 0, 0);
        idle(40, 0);
        n_tot++;
        if (got_cyc.size() != 1)
            $display("FAIL b2b_count got %0d want 1", got_cyc.size());
        else n_pass++;
        n_tot++;
        if (bus.xOut !== 16'h8000)
            $display("FAIL b2b_xout got %h want 8000", bus.xOut);
        else n_pass++;
        n_tot++;
        if (bus.overrun !== 1'b1)
            $display("FAIL b2b_overrun got %b want 1", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_spaced();
        do_reset();
        send_bits(16'h8000, W, 3, 0, 0);
        send_bits(16'h7FFF, W, 3, 0, 0);
        idle(5, 0);
        n_tot++;
        if (got_cyc.size() != 2)
            $display("FAIL spaced_count got %0d want 2", got_cyc.size());
        else n_pass++;
        n_tot++;
        if (got_cyc.size() == 2 && got_cyc[1] - got_cyc[0] != 48)
            $display("FAIL spaced_gap got %0d want 48",
                     got_cyc[1] - got_cyc[0]);
        else if (got_cyc.size() == 2) n_pass++;
        else $display("FAIL spaced_gap got no pair want 48");
        n_tot++;
        if (bus.xOut !== 16'h7FFF)
            $display("FAIL spaced_xout got %h want 7fff", bus.xOut);
        else n_pass++;
        n_tot++;
        if (bus.overrun !== 1'b0)
            $display("FAIL spaced_overrun got %b want 0", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        do_reset();
        send_bits(16'hFFFF, 7, 2, 0, 0);
        send_bits(16'h1234, W, 2, 0, 0);
        idle(5, 0);
        n_tot++;
        if (bus.frame_err !== 1'b1)
            $display("FAIL ferr_flag got %b want 1", bus.frame_err);
        else n_pass++;
        n_tot++;
        if (got_cyc.size() != 1)
            $display("FAIL ferr_count got %0d want 1", got_cyc.size());
        else n_pass++;
        n_tot++;
        if (bus.xOut !== 16'h1234)
            $display("FAIL ferr_xout got %h want 1234", bus.xOut);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_bits(16'hFFFF, 10, 1, 0, 0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tot++;
        if (got_cyc.size() != 0)
            $display("FAIL rmid_aborted got %0d strobes want 0",
                     got_cyc.size());
        else n_pass++;
        send_bits(16'h00FF, W, 1, 0, 0);
        idle(3, 0);
        n_tot++;
        if (got_cyc.size() != 1 || bus.xOut !== 16'h00FF)
            $display("FAIL rmid_xout got %h (%0d strobes) want 00ff",
                     bus.xOut, got_cyc.size());
        else n_pass++;
        n_tot++;
        if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0)
            $display("FAIL rmid_flags got %b%b want 00",
                     bus.overrun, bus.frame_err);
        else n_pass++;
    endtask

    task automatic test_fs_on_lsb();
        do_reset();
        send_bits(16'hC0DE, W, 2, 1, 0);
        idle(3, 0);
        n_tot++;
        if (bus.xOut !== 16'hC0DE || got_cyc.size() != 1)
            $display("FAIL fslsb_xout got %h (%0d strobes) want c0de",
                     bus.xOut, got_cyc.size());
        else n_pass++;
        n_tot++;
        if (bus.frame_err !== 1'b0)
            $display("FAIL fslsb_ferr got %b want 0", bus.frame_err);
        else n_pass++;
    endtask

    task automatic test_err_clr();
        do_reset();
        send_bits(16'h8000, W, 1, 0, 0);
        send_bits(16'h7FFF, W, 1, 0, 0);
        send_bits(16'h1111, W, 1, 0, 1);
        n_tot++;
        if (bus.overrun !== 1'b1)
            $display("FAIL clr_set_wins got %b want 1", bus.overrun);
        else n_pass++;
        idle(3, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_tot++;
        if (bus.overrun !== 1'b0)
            $display("FAIL clr_alone got %b want 0", bus.overrun);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        int           period;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            period = $urandom_range(1, 4);
            w      = W'($urandom);
            if ($urandom_range(0, 3) == 0)
                send_bits(~w, $urandom_range(1, W - 1), period, 0, 0);
            send_bits(w, W, period, 1'($urandom_range(0, 1)), 0);
            idle($urandom_range(0, 40), 1);
        end
        idle(3, 0);
        n_tot++;
        if (got_cyc.size() != exp_cyc.size())
            $display("FAIL rand_count got %0d want %0d",
                     got_cyc.size(), exp_cyc.size());
        else n_pass++;
        for (int i = 0; i < got_cyc.size() && i < exp_cyc.size(); i++) begin
            n_tot++;
            if (got_cyc[i] != exp_cyc[i] || got_val[i] !== exp_val[i])
                $display("FAIL rand_strobe%0d got %0d/%h want %0d/%h", i,
                         got_cyc[i], got_val[i], exp_cyc[i], exp_val[i]);
            else n_pass++;
        end
        n_tot++;
        if (bus.xOut !== m_xout)
            $display("FAIL rand_xout got %h want %h", bus.xOut, m_xout);
        else n_pass++;
        n_tot++;
        if (bus.overrun !== m_ovr || bus.frame_err !== m_ferr)
            $display("FAIL rand_flags got %b%b want %b%b",
                     bus.overrun, bus.frame_err, m_ovr, m_ferr);
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        bus.bit_en  = 1'b0;
        bus.fs      = 1'b0;
        bus.sdata   = 1'b0;
        bus.err_clr = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_spaced();
        test_frame_err();
        test_reset_mid();
        test_fs_on_lsb();
        test_err_clr();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
